fuzz_top_datapath: RTL and testbench

- Flat-bus registered datapath block sitting at the top of the rewiring fuzz harness.
- Slices one 155-bit input word into four 32-bit operands and a 27-bit control field.
- Computes ALU, accumulator, rotate, fold, counter and popcount results.
- Presents all results on one 159-bit registered output word, one clock after the input is sampled.

---
 rtl/fuzz_top_datapath.sv | 69 ++++++
 tb/tb_fuzz_top_datapath.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fuzz_top_datapath.sv
// fuzz_top_datapath: slices a flat operand/control word and registers ALU, accumulator, rotate, fold, counter and popcount results
module fuzz_top_datapath (
  input  logic         clk,
  input  logic         rst,
  input  logic [154:0] in_flat,
  output logic [158:0] out_flat
);
  logic [31:0] a, b, c, d, alu_n, rot_n;
  logic [26:0] ctrl;
  logic [2:0]  op;
  logic        load, acc_en, cnt_en;
  logic [4:0]  shamt;
  logic [15:0] mask, fold_n;
  logic [63:0] rot_w;
  logic [5:0]  pop_n;
  logic [32:0] sum_q;
  logic [31:0] alu_q, acc_q, rot_q;
  logic [15:0] fold_q;
  logic [7:0]  cnt_q;
  logic [5:0]  pop_q;
  assign a      = in_flat[31:0];
  assign b      = in_flat[63:32];
  assign c      = in_flat[95:64];
  assign d      = in_flat[127:96];
  assign ctrl   = in_flat[154:128];
  assign op     = ctrl[2:0];
  assign load   = ctrl[3];
  assign acc_en = ctrl[4];
  assign shamt  = ctrl[9:5];
  assign mask   = ctrl[25:10];
  assign cnt_en = ctrl[26];
  always_comb
    alu_n = op == 3'd0 ? a + c :
            op == 3'd1 ? a - c :
            op == 3'd2 ? a & c :
            op == 3'd3 ? a | c :
            op == 3'd4 ? a ^ c :
            op == 3'd5 ? b << shamt :
            op == 3'd6 ? b >> shamt :
            {31'b0, $signed(a) < $signed(c)};
  // Doubling d makes the upper half of a plain left shift a rotate.
  assign rot_w  = {d, d} << shamt;
  assign rot_n  = rot_w[63:32];
  assign fold_n = a[15:0] ^ a[31:16] ^ b[15:0] ^ b[31:16] ^ mask;
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < 27; i++) pop_n = pop_n + {5'b0, ctrl[i]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      alu_q  <= '0;
      acc_q  <= '0;
      rot_q  <= '0;
      fold_q <= '0;
      cnt_q  <= '0;
      pop_q  <= '0;
    end else begin
      sum_q  <= {1'b0, a} + {1'b0, b};
      alu_q  <= alu_n;
      acc_q  <= load ? d : acc_en ? acc_q + alu_n : acc_q;
      rot_q  <= rot_n;
      fold_q <= fold_n;
      cnt_q  <= cnt_en ? cnt_q + 8'd1 : cnt_q;
      pop_q  <= pop_n;
    end
  end
  assign out_flat = {pop_q, cnt_q, fold_q, rot_q, acc_q, alu_q, sum_q};
endmodule

// File: tb/tb_fuzz_top_datapath.sv
// tb_fuzz_top_datapath: directed vectors with hand-computed expectations for fuzz_top_datapath
module tb_fuzz_top_datapath;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [154:0] in_flat = '1;
  logic [158:0] out_flat;
  int vecs = 0;
  int errs = 0;
  fuzz_top_datapath dut (.clk(clk), .rst(rst), .in_flat(in_flat), .out_flat(out_flat));
  always #5 clk = ~clk;
  wire [32:0] sum_o  = out_flat[32:0];
  wire [31:0] alu_o  = out_flat[64:33];
  wire [31:0] acc_o  = out_flat[96:65];
  wire [31:0] rot_o  = out_flat[128:97];
  wire [15:0] fold_o = out_flat[144:129];
  wire [7:0]  cnt_o  = out_flat[152:145];
  wire [5:0]  pop_o  = out_flat[158:153];
  function automatic logic [26:0] mk_ctrl(input logic [2:0] op, input logic load, input logic acc_en,
                                          input logic [4:0] shamt, input logic [15:0] mask, input logic cnt_en);
    return {cnt_en, mask, shamt, acc_en, load, op};
  endfunction
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [26:0] ctrl);
    in_flat = {ctrl, d, c, b, a};
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_flat = '1;
    step();
    step();
    vecs++;
    if (out_flat !== 159'd0) begin
      errs++;
      $display("FAIL reset_out got=%h want=0", out_flat);
    end
    rst = 1'b0;
    step();
    vecs++;
    if (out_flat !== {6'd27, 8'd1, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33'h1FFFFFFFE}) begin
      errs++;
      $display("FAIL reset_release got=%h", out_flat);
    end
  endtask
  task automatic test_alu;
    drive(32'hFFFFFFFF, 32'd1, 32'd2, 32'd0, mk_ctrl(3'd1, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (sum_o !== 33'h100000000) begin errs++; $display("FAIL sum_carry got=%h want=100000000", sum_o); end
    vecs++;
    if (alu_o !== 32'hFFFFFFFD) begin errs++; $display("FAIL alu_sub got=%h want=fffffffd", alu_o); end
    vecs++;
    if (pop_o !== 6'd1) begin errs++; $display("FAIL pop_op1 got=%0d want=1", pop_o); end
    drive(32'h80000000, 32'd0, 32'd0, 32'd0, mk_ctrl(3'd7, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'd1) begin errs++; $display("FAIL alu_slt got=%h want=1", alu_o); end
    drive(32'hF0F0F0F0, 32'd0, 32'hFF00FF00, 32'd0, mk_ctrl(3'd2, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'hF000F000) begin errs++; $display("FAIL alu_and got=%h want=f000f000", alu_o); end
    drive(32'hF0F0F0F0, 32'd0, 32'hFF00FF00, 32'd0, mk_ctrl(3'd3, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'hFFF0FFF0) begin errs++; $display("FAIL alu_or got=%h want=fff0fff0", alu_o); end
    drive(32'hF0F0F0F0, 32'd0, 32'hFF00FF00, 32'd0, mk_ctrl(3'd4, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'h0FF00FF0) begin errs++; $display("FAIL alu_xor got=%h want=0ff00ff0", alu_o); end
    drive(32'd0, 32'd1, 32'd0, 32'd0, mk_ctrl(3'd5, 0, 0, 5'd4, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'h10) begin errs++; $display("FAIL alu_shl got=%h want=10", alu_o); end
    drive(32'd0, 32'h80000080, 32'd0, 32'd0, mk_ctrl(3'd6, 0, 0, 5'd4, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'h08000008) begin errs++; $display("FAIL alu_shr got=%h want=08000008", alu_o); end
    drive(32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, mk_ctrl(3'd7, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (alu_o !== 32'd0) begin errs++; $display("FAIL alu_slt_false got=%h want=0", alu_o); end
  endtask
  task automatic test_accumulator;
    logic [31:0] exp_acc [4] = '{32'd10, 32'd15, 32'd20, 32'd25};
    drive(32'd5, 32'd0, 32'd0, 32'd10, mk_ctrl(3'd0, 1, 0, 5'd0, 16'h0, 0));
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (acc_o !== exp_acc[i]) begin errs++; $display("FAIL acc_seq%0d got=%0d want=%0d", i, acc_o, exp_acc[i]); end
      drive(32'd5, 32'd0, 32'd0, 32'd10, mk_ctrl(3'd0, 0, 1, 5'd0, 16'h0, 0));
    end
    drive(32'd5, 32'd0, 32'd0, 32'd7, mk_ctrl(3'd0, 1, 1, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (acc_o !== 32'd7) begin errs++; $display("FAIL acc_load_prio got=%0d want=7", acc_o); end
    drive(32'd5, 32'd0, 32'd0, 32'd7, mk_ctrl(3'd0, 0, 0, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (acc_o !== 32'd7) begin errs++; $display("FAIL acc_hold got=%0d want=7", acc_o); end
    drive(32'd5, 32'd0, 32'd0, 32'd7, mk_ctrl(3'd0, 1, 1, 5'd0, 16'h0, 1));
    rst = 1'b1;
    step();
    vecs++;
    if (out_flat !== 159'd0) begin errs++; $display("FAIL acc_mid_reset got=%h want=0", out_flat); end
    rst = 1'b0;
    drive(32'd5, 32'd0, 32'd0, 32'd7, mk_ctrl(3'd0, 0, 1, 5'd0, 16'h0, 0));
    step();
    vecs++;
    if (acc_o !== 32'd5) begin errs++; $display("FAIL acc_after_reset got=%0d want=5", acc_o); end
  endtask
  task automatic test_rotate;
    logic [4:0]  sh  [3] = '{5'd1, 5'd0, 5'd31};
    logic [31:0] exp [3] = '{32'h00000003, 32'h80000001, 32'hC0000000};
    for (int i = 0; i < 3; i++) begin
      drive(32'd0, 32'd0, 32'd0, 32'h80000001, mk_ctrl(3'd0, 0, 0, sh[i], 16'h0, 0));
      step();
      vecs++;
      if (rot_o !== exp[i]) begin errs++; $display("FAIL rot_sh%0d got=%h want=%h", sh[i], rot_o, exp[i]); end
    end
  endtask
  task automatic test_fold_pop;
    drive(32'h12345678, 32'd0, 32'd0, 32'd0, 27'd0);
    step();
    vecs++;
    if (fold_o !== 16'h444C) begin errs++; $display("FAIL fold_basic got=%h want=444c", fold_o); end
    vecs++;
    if (pop_o !== 6'd0) begin errs++; $display("FAIL pop_zero got=%0d want=0", pop_o); end
    drive(32'h12345678, 32'hFFFF0000, 32'd0, 32'd0, mk_ctrl(3'd0, 0, 0, 5'd0, 16'h00FF, 0));
    step();
    vecs++;
    if (fold_o !== 16'hBB4C) begin errs++; $display("FAIL fold_mask got=%h want=bb4c", fold_o); end
    vecs++;
    if (pop_o !== 6'd8) begin errs++; $display("FAIL pop_mask got=%0d want=8", pop_o); end
    drive(32'd0, 32'd0, 32'd0, 32'd0, '1);
    step();
    vecs++;
    if (pop_o !== 6'd27) begin errs++; $display("FAIL pop_ones got=%0d want=27", pop_o); end
  endtask
  task automatic test_counter;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 27'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, mk_ctrl(3'd0, 0, 0, 5'd0, 16'h0, 1));
    for (int i = 0; i < 255; i++) step();
    vecs++;
    if (cnt_o !== 8'd255) begin errs++; $display("FAIL cnt_255 got=%0d want=255", cnt_o); end
    step();
    vecs++;
    if (cnt_o !== 8'd0) begin errs++; $display("FAIL cnt_wrap got=%0d want=0", cnt_o); end
    step();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 27'd0);
    step();
    step();
    vecs++;
    if (cnt_o !== 8'd1) begin errs++; $display("FAIL cnt_hold got=%0d want=1", cnt_o); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp [4] = '{32'd9, 32'd3, 32'd2, 32'd7};
    for (int i = 0; i < 4; i++) begin
      drive(32'd6, 32'd0, 32'd3, 32'd0, mk_ctrl(i[2:0], 0, 0, 5'd0, 16'h0, 0));
      step();
      vecs++;
      if (alu_o !== exp[i]) begin errs++; $display("FAIL b2b_op%0d got=%0d want=%0d", i, alu_o, exp[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_accumulator();
    test_rotate();
    test_fold_pop();
    test_counter();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
